// File: rtl/mci_pkg.sv
// mci_pkg: shared constants and types for the MCI watchdog chain.
// Channel FSM states plus the channel and period-width limits.
package mci_pkg;

    localparam int unsigned MCI_WDT_MAX_TIMERS = 8;
    localparam int unsigned MCI_WDT_TIMEOUT_PERIOD_NUM_DWORDS = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        EXPIRED = 2'd2
    } mci_wdt_state_e;

endpackage

// File: rtl/mci_wdt_chan.sv
// mci_wdt_chan: one watchdog channel, IDLE/COUNT/EXPIRED FSM and a
// CW-bit up-counter compared (>=) against a live period each cycle.
module mci_wdt_chan
    import mci_pkg::*;
#(
    parameter int unsigned CW = 64
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          en_i,
    input  logic          act_i,
    input  logic          restart_i,
    input  logic [CW-1:0] period_i,
    input  logic          serviced_i,
    output logic          timeout_o,
    output logic          timeout_p_o
);

    mci_wdt_state_e  state_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            timeout_q;
    logic            timeout_p_q;
    logic            expire;

    // >= compare so a period lowered below the count expires at once
    assign expire = (cnt_q >= period_i);

    // Saturating increment; the >= compare normally stops it first
    assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + CW'(1);

    // Channel FSM: disable > restart > expire > increment
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
            timeout_p_q <= 1'b0;
        end else begin
            timeout_p_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (act_i) begin
                        state_q <= COUNT;
                        cnt_q   <= '0;
                    end
                end
                COUNT: begin
                    if (!act_i) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (restart_i) begin
                        cnt_q <= '0;
                    end else if (expire) begin
                        state_q     <= EXPIRED;
                        timeout_q   <= 1'b1;
                        timeout_p_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                EXPIRED: begin
                    if (!en_i) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        timeout_q <= 1'b0;
                    end else if (serviced_i) begin
                        state_q   <= act_i ? COUNT : IDLE;
                        cnt_q     <= '0;
                        timeout_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    timeout_q <= 1'b0;
                end
            endcase
        end
    end

    assign timeout_o   = timeout_q;
    assign timeout_p_o = timeout_p_q;

endmodule

// File: rtl/mci_wdt_chain.sv
// mci_wdt_chain: N-channel watchdog, each channel free-running or gated
// by the previous channel's expiry, with a sticky fatal output for NMI.
module mci_wdt_chain
    import mci_pkg::*;
#(
    parameter int unsigned NUM_TIMERS        = 2,
    parameter int unsigned PERIOD_NUM_DWORDS = MCI_WDT_TIMEOUT_PERIOD_NUM_DWORDS,
    parameter logic [MCI_WDT_MAX_TIMERS-1:0] FATAL_TIMER_MASK = 8'b10
) (
    input  logic                                             clk,
    input  logic                                             rst_b,
    input  logic [NUM_TIMERS-1:0]                            timer_en,
    input  logic [NUM_TIMERS-1:0]                            timer_restart,
    input  logic [NUM_TIMERS-1:0]                            cascade_en,
    input  logic [NUM_TIMERS-1:0][PERIOD_NUM_DWORDS-1:0][31:0] timeout_period,
    input  logic [NUM_TIMERS-1:0]                            timeout_serviced,
    output logic [NUM_TIMERS-1:0]                            timeout,
    output logic [NUM_TIMERS-1:0]                            timeout_p,
    output logic                                             fatal_timeout
);

    localparam int unsigned CW = 32 * PERIOD_NUM_DWORDS;

    if (NUM_TIMERS < 1 || NUM_TIMERS > MCI_WDT_MAX_TIMERS) begin : g_bad_num
        $error("mci_wdt_chain: NUM_TIMERS must be 1..MCI_WDT_MAX_TIMERS");
    end

    if ((FATAL_TIMER_MASK >> NUM_TIMERS) != '0) begin : g_bad_mask
        $error("mci_wdt_chain: FATAL_TIMER_MASK has bits above NUM_TIMERS");
    end

    logic [NUM_TIMERS-1:0] act;
    logic [NUM_TIMERS-1:0] timeout_int;
    logic [NUM_TIMERS-1:0] timeout_p_int;
    logic                  fatal_hit;
    logic                  fatal_q;
    logic                  unused_cascade0;

    // Channel 0 has no predecessor, so its cascade bit is meaningless
    assign unused_cascade0 = cascade_en[0];
    assign act[0]          = timer_en[0];

    for (genvar i = 1; i < NUM_TIMERS; i++) begin : g_act
        assign act[i] = timer_en[i] & (~cascade_en[i] | timeout_int[i-1]);
    end

    for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_chan
        mci_wdt_chan #(
            .CW (CW)
        ) u_chan (
            .clk         (clk),
            .rst_b       (rst_b),
            .en_i        (timer_en[i]),
            .act_i       (act[i]),
            .restart_i   (timer_restart[i]),
            .period_i    (timeout_period[i]),
            .serviced_i  (timeout_serviced[i]),
            .timeout_o   (timeout_int[i]),
            .timeout_p_o (timeout_p_int[i])
        );
    end

    assign fatal_hit = |(timeout_p_int & FATAL_TIMER_MASK[NUM_TIMERS-1:0]);

    // Fatal is sticky: only reset clears it
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            fatal_q <= 1'b0;
        end else begin
            fatal_q <= fatal_q | fatal_hit;
        end
    end

    assign timeout       = timeout_int;
    assign timeout_p     = timeout_p_int;
    assign fatal_timeout = fatal_q;

endmodule

// File: tb/tb_mci_wdt_chain.sv
// tb_mci_wdt_chain: directed stimulus with expected expiry pulses queued
// per DUT; a negedge monitor pops and checks every timeout_p it sees.
module tb_mci_wdt_chain;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT0: 2 channels, 64-bit period, fatal mask 'b10
    logic [1:0]             en0, rs0, ce0, sv0, to0, tp0;
    logic [1:0][1:0][31:0]  per0;
    logic                   ft0;

    // DUT1: 4 channels, 32-bit period, fatal mask 'b0101
    logic [3:0]             en1, rs1, ce1, sv1, to1, tp1;
    logic [3:0][0:0][31:0]  per1;
    logic                   ft1;

    mci_wdt_chain #(
        .NUM_TIMERS        (2),
        .PERIOD_NUM_DWORDS (2),
        .FATAL_TIMER_MASK  (8'b10)
    ) u_dut0 (
        .clk              (clk),
        .rst_b            (rst_b),
        .timer_en         (en0),
        .timer_restart    (rs0),
        .cascade_en       (ce0),
        .timeout_period   (per0),
        .timeout_serviced (sv0),
        .timeout          (to0),
        .timeout_p        (tp0),
        .fatal_timeout    (ft0)
    );

    mci_wdt_chain #(
        .NUM_TIMERS        (4),
        .PERIOD_NUM_DWORDS (1),
        .FATAL_TIMER_MASK  (8'b0101)
    ) u_dut1 (
        .clk              (clk),
        .rst_b            (rst_b),
        .timer_en         (en1),
        .timer_restart    (rs1),
        .cascade_en       (ce1),
        .timeout_period   (per1),
        .timeout_serviced (sv1),
        .timeout          (to1),
        .timeout_p        (tp1),
        .fatal_timeout    (ft1)
    );

    typedef struct {
        int ch;
        int cy;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h @cyc %0d", nm, got, want, cyc);
        end
    endtask

    task automatic push(input int d, input int ch, input int cy);
        exp_t e;
        e.ch = ch;
        e.cy = cy;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic mon_pop(input int d, input int ch);
        exp_t e;
        int   sz;
        n_cmp++;
        sz = (d == 0) ? q0.size() : q1.size();
        if (sz == 0) begin
            n_err++;
            $display("FAIL pulse_dut%0d: got timeout_p[%0d] @cyc %0d want none",
                     d, ch, cyc);
        end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            if (e.ch != ch || e.cy != cyc) begin
                n_err++;
                $display("FAIL pulse_dut%0d: got ch%0d @cyc %0d want ch%0d @cyc %0d",
                         d, ch, cyc, e.ch, e.cy);
            end
        end
    endtask

    // Monitor: every observed expiry pulse must match the queue head
    always @(negedge clk) begin
        if (rst_b) begin
            for (int i = 0; i < 2; i++) if (tp0[i]) mon_pop(0, i);
            for (int i = 0; i < 4; i++) if (tp1[i]) mon_pop(1, i);
        end
    end

    task automatic goto(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic drain(input string nm);
        for (int k = 0; k < 300 && (q0.size() + q1.size()) != 0; k++)
            @(negedge clk);
        @(negedge clk);
        chk(nm, 64'(q0.size() + q1.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int c;
        int d;
        en0 = '0; rs0 = '0; ce0 = '0; sv0 = '0; per0 = '0;
        en1 = '0; rs1 = '0; ce1 = '0; sv1 = '0; per1 = '0;
        rst_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_to0", 64'(to0), 0);
        chk("rst_tp0", 64'(tp0), 0);
        chk("rst_ft0", 64'(ft0), 0);
        chk("rst_to1", 64'(to1), 0);
        chk("rst_tp1", 64'(tp1), 0);
        chk("rst_ft1", 64'(ft1), 0);
        rst_b = 1'b1;
        @(negedge clk);

        // Independent expiry, hold, service and restart
        c = cyc;
        per0[0] = 64'd10;
        en0 = 2'b01;
        push(0, 0, c + 12);
        goto(c + 11);
        chk("t1_pre", 64'(to0[0]), 0);
        goto(c + 12);
        chk("t1_exp", 64'(to0[0]), 1);
        goto(c + 20);
        chk("t1_hold", 64'(to0[0]), 1);
        d = cyc;
        sv0 = 2'b01;
        @(negedge clk);
        sv0 = 2'b00;
        push(0, 0, d + 12);
        chk("t1_svc_clr", 64'(to0[0]), 0);
        goto(d + 12);
        chk("t1_reexp", 64'(to0[0]), 1);
        en0 = 2'b00;
        @(negedge clk);
        chk("t1_dis", 64'(to0[0]), 0);
        chk("t1_nofatal", 64'(ft0), 0);
        drain("t1_drain");

        // Cascade drop: ch0 serviced while ch1 holds cnt=2
        c = cyc;
        per0[0] = 64'd5;
        per0[1] = 64'd3;
        ce0 = 2'b10;
        en0 = 2'b11;
        push(0, 0, c + 7);
        goto(c + 10);
        sv0 = 2'b01;
        push(0, 0, c + 17);
        @(negedge clk);
        sv0 = 2'b00;
        goto(c + 12);
        chk("t3_ch1_lvl", 64'(to0[1]), 0);
        goto(c + 17);
        chk("t3_ch0_re", 64'(to0[0]), 1);
        en0 = 2'b00;
        @(negedge clk);
        chk("t3_nofatal", 64'(ft0), 0);
        drain("t3_drain");

        // Cascade expiry drives fatal, which survives service and disable
        c = cyc;
        per0[0] = 64'd5;
        per0[1] = 64'd3;
        ce0 = 2'b10;
        en0 = 2'b11;
        push(0, 0, c + 7);
        push(0, 1, c + 12);
        goto(c + 12);
        chk("t2_ft_pre", 64'(ft0), 0);
        goto(c + 13);
        chk("t2_ft_set", 64'(ft0), 1);
        sv0 = 2'b11;
        @(negedge clk);
        sv0 = 2'b00;
        en0 = 2'b00;
        chk("t2_ft_svc", 64'(ft0), 1);
        @(negedge clk);
        @(negedge clk);
        chk("t2_ft_dis", 64'(ft0), 1);
        chk("t2_to_dis", 64'(to0), 0);
        ce0 = 2'b00;
        drain("t2_drain");

        // Periodic restart keeps the channel from expiring
        per0[0] = 64'd10;
        en0 = 2'b01;
        for (int i = 0; i < 125; i++) begin
            repeat (7) @(negedge clk);
            rs0 = 2'b01;
            @(negedge clk);
            rs0 = 2'b00;
        end
        chk("t4_noexp", 64'(to0[0]), 0);
        en0 = 2'b00;
        @(negedge clk);
        @(negedge clk);
        // Restart on the would-be expiry edge suppresses the pulse
        c = cyc;
        en0 = 2'b01;
        goto(c + 11);
        rs0 = 2'b01;
        @(negedge clk);
        rs0 = 2'b00;
        chk("t4_rs_exp", 64'(to0[0]), 0);
        push(0, 0, c + 23);
        goto(c + 23);
        chk("t4_late_exp", 64'(to0[0]), 1);
        en0 = 2'b00;
        drain("t4_drain");

        // Wide period, then lowered below the running count
        per0[0] = 64'hFFFF_FFFF_0000_0000;
        c = cyc;
        en0 = 2'b01;
        goto(c + 101);
        chk("t5_wide", 64'(to0[0]), 0);
        per0[0] = 64'd3;
        push(0, 0, c + 102);
        goto(c + 102);
        chk("t5_shrink", 64'(to0[0]), 1);
        en0 = 2'b00;
        @(negedge clk);
        @(negedge clk);
        // Upper dword alone must hold off expiry
        per0[0] = 64'h0000_0001_0000_0000;
        c = cyc;
        en0 = 2'b01;
        goto(c + 100);
        chk("t5_hi_dw", 64'(to0[0]), 0);
        per0[0] = 64'd50;
        push(0, 0, c + 101);
        goto(c + 101);
        chk("t5_lo_dw", 64'(to0[0]), 1);
        en0 = 2'b00;
        drain("t5_drain");

        // Four channels, async reset mid-count, masked fatal
        per1[0] = 32'd2;
        per1[1] = 32'd20;
        per1[2] = 32'd2;
        per1[3] = 32'd20;
        c = cyc;
        en1 = 4'hF;
        push(1, 0, c + 4);
        push(1, 2, c + 4);
        goto(c + 5);
        chk("t6_ft_pre", 64'(ft1), 1);
        chk("t6_to_pre", 64'(to1), 4'b0101);
        goto(c + 8);
        rst_b = 1'b0;
        #1;
        chk("t6_rst_to1", 64'(to1), 0);
        chk("t6_rst_tp1", 64'(tp1), 0);
        chk("t6_rst_ft1", 64'(ft1), 0);
        chk("t6_rst_ft0", 64'(ft0), 0);
        en1 = 4'h0;
        @(negedge clk);
        rst_b = 1'b1;
        per1[2] = 32'd4;
        per1[3] = 32'd4;
        @(negedge clk);
        c = cyc;
        en1 = 4'b1000;
        push(1, 3, c + 6);
        goto(c + 7);
        chk("t6_ch3_lvl", 64'(to1), 4'b1000);
        chk("t6_ch3_nof", 64'(ft1), 0);
        en1 = 4'h0;
        @(negedge clk);
        c = cyc;
        en1 = 4'b0100;
        push(1, 2, c + 6);
        goto(c + 6);
        chk("t6_ch2_pre", 64'(ft1), 0);
        goto(c + 7);
        chk("t6_ch2_fat", 64'(ft1), 1);
        en1 = 4'h0;
        drain("t6_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
